pa_ram_rd_arbiter: RTL and testbench

Shares the single data-RAM read port between the partition-algorithm engines: the mean calculator, the partition/swap unit, the output streamer, and a spare. Each cycle it grants at most one read request, round-robin. It issues that request to the RAM and remembers which requester owns it in an in-order tag FIFO. It then steers each returning RAM word back to its owner. The block sits between the PA engines and the RAM controller; engines never drive the RAM directly.

---
 rtl/pa_pkg.sv | 20 ++
 rtl/pa_tag_fifo.sv | 51 +++++
 rtl/pa_ram_rd_arbiter.sv | 101 ++++++++++
 tb/tb_pa_ram_rd_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pa_pkg.sv
// Shared partition-algorithm types: requester tag and one-hot decode helper.
// Tags are sized for the largest supported requester count (8).
package pa_pkg;

   localparam int PA_MAX_REQ = 8;
   localparam int PA_TAG_W   = 3;

   typedef logic [PA_TAG_W-1:0] pa_tag_t;

   // OR-reduction encoder; the input is assumed one-hot (or all zero).
   function automatic pa_tag_t pa_onehot_to_idx(input logic [PA_MAX_REQ-1:0] oh);
      pa_tag_t idx;
      idx = '0;
      for (int i = 0; i < PA_MAX_REQ; i++) begin
         if (oh[i]) idx = idx | pa_tag_t'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/pa_tag_fifo.sv
// In-order tag FIFO recording which requester owns each outstanding RAM read.
// Pointers wrap modulo DEPTH; a push when full or a pop when empty is ignored.
module pa_tag_fifo
   import pa_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  pa_tag_t                push_tag,
   input  logic                   pop,
   output pa_tag_t                pop_tag,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   pa_tag_t         mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic            push_ok;
   logic            pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign pop_tag = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
         count <= count + CW'(push_ok) - CW'(pop_ok);
      end
   end

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_tag;
   end

endmodule

// File: rtl/pa_ram_rd_arbiter.sv
// Round-robin arbiter sharing the data-RAM read port between PA engines;
// routes each in-order RAM return back to the requester that issued it.
module pa_ram_rd_arbiter
   import pa_pkg::*;
#(
   parameter int SIZE_ADDR = 32,
   parameter int SIZE_DATA = 32,
   parameter int NUM_REQ   = 4,
   parameter int MAX_OUTST = 4
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic [NUM_REQ-1:0]           i_req,
   input  logic [NUM_REQ*SIZE_ADDR-1:0] i_req_addr,
   output logic [NUM_REQ-1:0]           o_gnt,
   output logic [NUM_REQ-1:0]           o_rvalid,
   output logic [SIZE_DATA-1:0]         o_rdata,
   output logic                         o_ram_en,
   output logic [SIZE_ADDR-1:0]         o_ram_addr,
   input  logic [SIZE_DATA-1:0]         i_ram_data,
   input  logic                         i_ram_valid,
   output logic                         o_busy,
   output logic                         o_err
);

   localparam int CW = $clog2(MAX_OUTST) + 1;

   pa_tag_t            rr_ptr;
   logic [NUM_REQ-1:0] gnt_c;
   pa_tag_t            gnt_idx;
   logic               push;
   logic               pop;
   logic               full;
   logic               empty;
   logic [CW-1:0]      count;
   logic [CW-1:0]      count_nxt;
   pa_tag_t            pop_tag;

   // Search starts at rr_ptr; a full FIFO (registered count) blocks any grant.
   always_comb begin
      logic found;
      int   cand;
      gnt_c = '0;
      found = 1'b0;
      cand  = 0;
      if (!i_rst && !full) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!found && i_req[cand]) begin
               found       = 1'b1;
               gnt_c[cand] = 1'b1;
            end
         end
      end
   end

   assign gnt_idx   = pa_onehot_to_idx(PA_MAX_REQ'(gnt_c));
   assign o_gnt     = gnt_c;
   assign push      = |gnt_c;
   assign pop       = i_ram_valid && !empty;
   assign count_nxt = count + CW'(push) - CW'(pop);

   pa_tag_fifo #(
      .DEPTH (MAX_OUTST)
   ) u_tag_fifo (
      .clk      (i_clk),
      .rst      (i_rst),
      .push     (push),
      .push_tag (gnt_idx),
      .pop      (pop),
      .pop_tag  (pop_tag),
      .full     (full),
      .empty    (empty),
      .count    (count)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rr_ptr     <= '0;
         o_ram_en   <= 1'b0;
         o_ram_addr <= '0;
         o_rvalid   <= '0;
         o_rdata    <= '0;
         o_busy     <= 1'b0;
         o_err      <= 1'b0;
      end else begin
         o_ram_en <= push;
         if (push) begin
            rr_ptr     <= (gnt_idx == pa_tag_t'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
            o_ram_addr <= i_req_addr[gnt_idx*SIZE_ADDR +: SIZE_ADDR];
         end
         o_rvalid <= pop ? (NUM_REQ'(1) << pop_tag) : '0;
         if (pop) o_rdata <= i_ram_data;
         // Busy looks at the post-update count so it rises with the first issued read.
         o_busy <= (count_nxt != '0);
         if (i_ram_valid && empty) o_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pa_ram_rd_arbiter.sv
// Directed bench for pa_ram_rd_arbiter: vector table plus corner-case sequences.
module tb_pa_ram_rd_arbiter;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [3:0]   req = '0;
   logic [127:0] req_addr = '0;
   logic [3:0]   gnt;
   logic [3:0]   rvalid;
   logic [31:0]  rdata;
   logic         ram_en;
   logic [31:0]  ram_addr;
   logic [31:0]  ram_data = '0;
   logic         ram_valid = 1'b0;
   logic         busy;
   logic         err;

   int total  = 0;
   int passed = 0;

   pa_ram_rd_arbiter #(
      .SIZE_ADDR (32),
      .SIZE_DATA (32),
      .NUM_REQ   (4),
      .MAX_OUTST (4)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req       (req),
      .i_req_addr  (req_addr),
      .o_gnt       (gnt),
      .o_rvalid    (rvalid),
      .o_rdata     (rdata),
      .o_ram_en    (ram_en),
      .o_ram_addr  (ram_addr),
      .i_ram_data  (ram_data),
      .i_ram_valid (ram_valid),
      .o_busy      (busy),
      .o_err       (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst_b;
      logic [3:0]  req;
      logic        rv;
      logic [31:0] rd;
      logic [3:0]  eg;
      logic        een;
      logic [31:0] eaddr;
      logic [3:0]  erv;
      logic [31:0] erd;
      logic        ebusy;
      logic        eerr;
   } vec_t;

   typedef struct {
      int          tag;
      logic [31:0] addr;
   } sb_t;

   vec_t tbl [22];
   sb_t  sbq [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req       = '0;
      ram_valid = 1'b0;
      ram_data  = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic cyc(input logic [3:0] r, input logic rv, input logic [31:0] rd);
      @(posedge clk);
      #1;
      req       = r;
      ram_valid = rv;
      ram_data  = rd;
      #1;
   endtask

   initial begin
      logic [31:0] a [4];
      int          exp_ptr;
      int          k;
      sb_t         e;

      // single requester, then fairness, spurious return and sticky error
      tbl[0]  = '{1, 4'h1, 0, 32'h0,    4'h1, 0, 32'h00, 4'h0, 32'h0,    0, 0};
      tbl[1]  = '{0, 4'h0, 0, 32'h0,    4'h0, 1, 32'h10, 4'h0, 32'h0,    1, 0};
      tbl[2]  = '{0, 4'h0, 0, 32'h0,    4'h0, 0, 32'h10, 4'h0, 32'h0,    1, 0};
      tbl[3]  = '{0, 4'h0, 1, 32'hAAAA, 4'h0, 0, 32'h10, 4'h0, 32'h0,    1, 0};
      tbl[4]  = '{0, 4'h0, 0, 32'h0,    4'h0, 0, 32'h10, 4'h1, 32'hAAAA, 0, 0};
      tbl[5]  = '{0, 4'h0, 0, 32'h0,    4'h0, 0, 32'h10, 4'h0, 32'hAAAA, 0, 0};
      tbl[6]  = '{1, 4'hF, 0, 32'h0,    4'h1, 0, 32'h00, 4'h0, 32'h0,    0, 0};
      tbl[7]  = '{0, 4'hF, 1, 32'hB0,   4'h2, 1, 32'h10, 4'h0, 32'h0,    1, 0};
      tbl[8]  = '{0, 4'hF, 1, 32'hB1,   4'h4, 1, 32'h20, 4'h1, 32'hB0,   1, 0};
      tbl[9]  = '{0, 4'hF, 1, 32'hB2,   4'h8, 1, 32'h30, 4'h2, 32'hB1,   1, 0};
      tbl[10] = '{0, 4'hF, 1, 32'hB3,   4'h1, 1, 32'h40, 4'h4, 32'hB2,   1, 0};
      tbl[11] = '{0, 4'hF, 1, 32'hB0,   4'h2, 1, 32'h10, 4'h8, 32'hB3,   1, 0};
      tbl[12] = '{0, 4'hF, 1, 32'hB1,   4'h4, 1, 32'h20, 4'h1, 32'hB0,   1, 0};
      tbl[13] = '{0, 4'hF, 1, 32'hB2,   4'h8, 1, 32'h30, 4'h2, 32'hB1,   1, 0};
      tbl[14] = '{0, 4'h0, 1, 32'hB3,   4'h0, 1, 32'h40, 4'h4, 32'hB2,   1, 0};
      tbl[15] = '{0, 4'h0, 0, 32'h0,    4'h0, 0, 32'h40, 4'h8, 32'hB3,   0, 0};
      tbl[16] = '{0, 4'h0, 0, 32'h0,    4'h0, 0, 32'h40, 4'h0, 32'hB3,   0, 0};
      tbl[17] = '{0, 4'h0, 1, 32'hEE,   4'h0, 0, 32'h40, 4'h0, 32'hB3,   0, 0};
      tbl[18] = '{0, 4'h0, 0, 32'h0,    4'h0, 0, 32'h40, 4'h0, 32'hB3,   0, 1};
      tbl[19] = '{0, 4'h2, 0, 32'h0,    4'h2, 0, 32'h40, 4'h0, 32'hB3,   0, 1};
      tbl[20] = '{0, 4'h0, 1, 32'hC1,   4'h0, 1, 32'h20, 4'h0, 32'hB3,   1, 1};
      tbl[21] = '{0, 4'h0, 0, 32'h0,    4'h0, 0, 32'h20, 4'h2, 32'hC1,   0, 1};

      req_addr = {32'h40, 32'h30, 32'h20, 32'h10};
      for (int i = 0; i < 22; i++) begin
         if (tbl[i].rst_b) do_reset();
         cyc(tbl[i].req, tbl[i].rv, tbl[i].rd);
         chk($sformatf("v%0d gnt", i),    32'(gnt),    32'(tbl[i].eg));
         chk($sformatf("v%0d ram_en", i), 32'(ram_en), 32'(tbl[i].een));
         chk($sformatf("v%0d ram_addr", i), ram_addr,  tbl[i].eaddr);
         chk($sformatf("v%0d rvalid", i), 32'(rvalid), 32'(tbl[i].erv));
         chk($sformatf("v%0d rdata", i),  rdata,       tbl[i].erd);
         chk($sformatf("v%0d busy", i),   32'(busy),   32'(tbl[i].ebusy));
         chk($sformatf("v%0d err", i),    32'(err),    32'(tbl[i].eerr));
      end

      // full FIFO: four grants, stall, pop does not free a slot until next cycle
      do_reset();
      for (int c = 0; c < 6; c++) begin
         cyc(4'h2, 1'b0, 32'h0);
         chk($sformatf("full c%0d gnt", c), 32'(gnt), (c < 4) ? 32'h2 : 32'h0);
      end
      chk("full busy", 32'(busy), 32'h1);
      cyc(4'h2, 1'b1, 32'h11);
      chk("full pop-cycle gnt", 32'(gnt), 32'h0);
      cyc(4'h2, 1'b0, 32'h0);
      chk("full regrant gnt", 32'(gnt), 32'h2);
      chk("full rvalid", 32'(rvalid), 32'h2);
      chk("full rdata", rdata, 32'h11);
      for (int c = 0; c < 4; c++) cyc(4'h0, 1'b1, 32'h20 + 32'(c));
      cyc(4'h0, 1'b0, 32'h0);
      chk("drain rvalid", 32'(rvalid), 32'h2);
      chk("drain rdata", rdata, 32'h23);
      chk("drain busy", 32'(busy), 32'h0);
      chk("drain ram_en", 32'(ram_en), 32'h0);
      chk("drain err", 32'(err), 32'h0);

      // reset with three reads in flight
      do_reset();
      for (int c = 0; c < 3; c++) cyc(4'hF, 1'b0, 32'h0);
      @(posedge clk);
      #1 req = 4'hF;
      #1 rst = 1'b1;
      #1;
      chk("rst gnt", 32'(gnt), 32'h0);
      chk("rst ram_en", 32'(ram_en), 32'h0);
      chk("rst ram_addr", ram_addr, 32'h0);
      chk("rst rvalid", 32'(rvalid), 32'h0);
      chk("rst rdata", rdata, 32'h0);
      chk("rst busy", 32'(busy), 32'h0);
      chk("rst err", 32'(err), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      req = 4'h0;
      cyc(4'h0, 1'b1, 32'hDEAD);
      cyc(4'hF, 1'b0, 32'h0);
      chk("post-rst gnt", 32'(gnt), 32'h1);
      chk("post-rst err", 32'(err), 32'h1);
      chk("post-rst rvalid", 32'(rvalid), 32'h0);

      // streaming with RAM latency 1 and a routing scoreboard
      do_reset();
      for (int i = 0; i < 4; i++) a[i] = $urandom;
      exp_ptr = 0;
      for (int c = 0; c < 103; c++) begin
         @(posedge clk);
         #1;
         req       = (c < 100) ? 4'hF : 4'h0;
         req_addr  = {a[3], a[2], a[1], a[0]};
         ram_valid = ram_en;
         ram_data  = ram_addr ^ 32'h5A5A_0000;
         #1;
         if (c < 100) begin
            chk($sformatf("stream c%0d gnt", c), 32'(gnt), 32'h1 << exp_ptr);
            if (c > 0) chk($sformatf("stream c%0d busy", c), 32'(busy), 32'h1);
         end
         if (gnt != '0) begin
            k = (gnt[0]) ? 0 : (gnt[1]) ? 1 : (gnt[2]) ? 2 : 3;
            sbq.push_back('{k, a[k]});
            a[k]    = $urandom;
            exp_ptr = (exp_ptr + 1) % 4;
         end
         if (rvalid != '0) begin
            if (sbq.size() == 0) begin
               chk("stream unexpected rvalid", 32'(rvalid), 32'h0);
            end else begin
               e = sbq.pop_front();
               chk($sformatf("stream c%0d rvalid", c), 32'(rvalid), 32'h1 << e.tag);
               chk($sformatf("stream c%0d rdata", c), rdata, e.addr ^ 32'h5A5A_0000);
            end
         end
      end
      chk("stream scoreboard empty", 32'(sbq.size()), 32'h0);
      chk("stream err", 32'(err), 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
